// File: rtl/feistel_decrypt.sv
// Iterative 256-bit Feistel decryptor: serially loaded byte S-box, five round keys,
// one round every F_LAT cycles, one block in flight.
module feistel_decrypt #(
  parameter int ROUND      = 5,
  parameter int F_LAT      = 6,
  parameter int SBOX_WIDTH = 8,
  parameter int KEY_SIZE   = 128,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SBOX_WIDTH-1:0] sbox_out,
  input  logic                  sbox_valid,
  input  logic                  key_valid,
  input  logic [KEY_SIZE-1:0]   K0,
  input  logic [KEY_SIZE-1:0]   K1,
  input  logic [KEY_SIZE-1:0]   K2,
  input  logic [KEY_SIZE-1:0]   K3,
  input  logic [KEY_SIZE-1:0]   K4,
  input  logic                  tvalid,
  input  logic [DATA_WIDTH-1:0] ciphertext,
  output logic                  tready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] plaintext,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 2 ** SBOX_WIDTH;
  localparam int NB    = KEY_SIZE / SBOX_WIDTH;
  localparam int RW    = (ROUND > 1) ? $clog2(ROUND) : 1;
  localparam int LW    = (F_LAT > 1) ? $clog2(F_LAT) : 1;
  localparam logic [RW-1:0]         RND_FIRST = RW'(ROUND - 1);
  localparam logic [LW-1:0]         LAT_LAST  = LW'(F_LAT - 1);
  localparam logic [SBOX_WIDTH-1:0] ADDR_LAST = SBOX_WIDTH'(DEPTH - 1);

  // Handshake: a block transfers on a rising edge where tvalid and tready are both high;
  // tready is never held off by anything but sbox/key readiness and a busy core.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                  r_state, w_next;
  logic [SBOX_WIDTH-1:0]   r_sbox [DEPTH];
  logic [SBOX_WIDTH-1:0]   r_wr_addr;
  logic                    r_sbox_ready;
  logic                    r_keys_ok;
  logic [KEY_SIZE-1:0]     r_key [5];
  logic [RW-1:0]           r_rnd;
  logic [LW-1:0]           r_lat;
  logic [KEY_SIZE-1:0]     r_l, r_r;
  logic [DATA_WIDTH-1:0]   r_pt;
  logic                    r_valid;
  logic [KEY_SIZE-1:0]     w_key, w_sub, w_f;
  logic                    w_tready, w_sbox_wr, w_last_lat;

  assign w_tready   = r_sbox_ready & r_keys_ok & (r_state == IDLE);
  assign w_sbox_wr  = sbox_valid & ~r_sbox_ready;
  assign w_last_lat = (r_lat == LAT_LAST);
  assign tready     = w_tready;
  assign valid      = r_valid;
  assign plaintext  = r_pt;
  assign dbg_state  = r_state;

  always_comb begin
    w_key = r_key[0];
    for (int k = 1; k < 5; k++)
      if (r_rnd == k[RW-1:0]) w_key = r_key[k];
  end

  // Byte-wise substitution of L ^ K, then the whole word rotates left by one entry.
  always_comb begin
    w_sub = '0;
    for (int b = 0; b < NB; b++)
      w_sub[b*SBOX_WIDTH +: SBOX_WIDTH] =
        r_sbox[r_l[b*SBOX_WIDTH +: SBOX_WIDTH] ^ w_key[b*SBOX_WIDTH +: SBOX_WIDTH]];
    w_f = {w_sub[KEY_SIZE-SBOX_WIDTH-1:0], w_sub[KEY_SIZE-1 -: SBOX_WIDTH]};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (tvalid && w_tready) w_next = RUN;
      RUN:     if (w_last_lat && r_rnd == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Table contents survive reset but are unusable until reloaded (sbox_ready clears).
  always_ff @(posedge clk) begin
    if (!reset && w_sbox_wr) r_sbox[r_wr_addr] <= sbox_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wr_addr    <= '0;
      r_sbox_ready <= 1'b0;
      r_keys_ok    <= 1'b0;
      for (int k = 0; k < 5; k++) r_key[k] <= '0;
      r_rnd        <= '0;
      r_lat        <= '0;
      r_l          <= '0;
      r_r          <= '0;
      r_pt         <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      if (w_sbox_wr) begin
        r_wr_addr <= r_wr_addr + 1'b1;
        if (r_wr_addr == ADDR_LAST) r_sbox_ready <= 1'b1;
      end
      if (key_valid && r_state == IDLE) begin
        r_key[0]  <= K0;
        r_key[1]  <= K1;
        r_key[2]  <= K2;
        r_key[3]  <= K3;
        r_key[4]  <= K4;
        r_keys_ok <= 1'b1;
      end
      case (r_state)
        IDLE: if (tvalid && w_tready) begin
          r_l   <= ciphertext[DATA_WIDTH-1:KEY_SIZE];
          r_r   <= ciphertext[KEY_SIZE-1:0];
          r_rnd <= RND_FIRST;
          r_lat <= '0;
        end
        RUN: if (w_last_lat) begin
          r_l   <= r_r ^ w_f;
          r_r   <= r_l;
          r_lat <= '0;
          if (r_rnd != '0) r_rnd <= r_rnd - 1'b1;
        end else begin
          r_lat <= r_lat + 1'b1;
        end
        DONE: begin
          r_pt    <= {r_l, r_r};
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_feistel_decrypt.sv
// Directed bench for feistel_decrypt: ciphertexts come from a reference encryptor,
// results are matched against the original plaintexts and the expected timing.
module tb_feistel_decrypt;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   sbox_out = '0;
  logic         sbox_valid = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] K0 = '0, K1 = '0, K2 = '0, K3 = '0, K4 = '0;
  logic         tvalid = 1'b0;
  logic [255:0] ciphertext = '0;
  logic         tready, valid;
  logic [255:0] plaintext;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [255:0] exp_q[$];
  logic [255:0] pt_q[$];
  int           vcyc_q[$];

  logic [7:0]   m_sbox [256];
  logic [127:0] m_keys [5];

  localparam logic [255:0] PT_A = {128'h112233445566778899aabbccddeeff00,
                                   128'h00112233445566778899aabbccddeeff};
  localparam logic [255:0] PT_B = {128'h0123456789abcdeffedcba9876543210,
                                   128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0};

  feistel_decrypt dut (
    .clk(clk), .reset(reset), .sbox_out(sbox_out), .sbox_valid(sbox_valid),
    .key_valid(key_valid), .K0(K0), .K1(K1), .K2(K2), .K3(K3), .K4(K4),
    .tvalid(tvalid), .ciphertext(ciphertext), .tready(tready), .valid(valid),
    .plaintext(plaintext), .dbg_state(dbg_state)
  );

  // clock / cycle counter / result monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcyc_q.push_back(cyc);
      pt_q.push_back(plaintext);
    end
  end

  // reference model: encryption direction
  function automatic logic [127:0] f_model(input logic [127:0] x, input logic [127:0] k);
    logic [127:0] y;
    for (int b = 0; b < 16; b++) y[b*8 +: 8] = m_sbox[x[b*8 +: 8] ^ k[b*8 +: 8]];
    return {y[119:0], y[127:120]};
  endfunction

  function automatic logic [255:0] encrypt(input logic [255:0] pt);
    logic [127:0] l, r, t;
    l = pt[255:128];
    r = pt[127:0];
    for (int i = 0; i < 5; i++) begin
      t = l ^ f_model(r, m_keys[i]);
      l = r;
      r = t;
    end
    return {l, r};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_sbox();
    for (int i = 0; i < 256; i++) begin
      sbox_valid = 1'b1;
      sbox_out   = 8'(255 - i);
      tick();
    end
    sbox_valid = 1'b0;
  endtask

  task automatic load_keys(input logic [127:0] a, b, c, d, e);
    K0 = a; K1 = b; K2 = c; K3 = d; K4 = e;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic load_std_keys();
    load_keys(m_keys[0], m_keys[1], m_keys[2], m_keys[3], m_keys[4]);
  endtask

  // raises tvalid with ct and returns the cycle number of the accepting edge
  task automatic send_block(input logic [255:0] ct, output int acc, output bit ok);
    int n;
    tvalid = 1'b1;
    ciphertext = ct;
    n = 0;
    while (tready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    ok = (tready === 1'b1);
    acc = 0;
    if (ok) begin
      tick();
      acc = cyc;
    end
  endtask

  task automatic wait_results(input int n, output bit ok);
    int t;
    t = 0;
    while (pt_q.size() < n && t < 200) begin
      tick();
      t++;
    end
    ok = (pt_q.size() >= n);
  endtask

  task automatic clear_q();
    pt_q.delete();
    vcyc_q.delete();
    exp_q.delete();
  endtask

  // runs one block of PT_A and checks value and latency
  task automatic round_trip(input string name);
    int acc, lat;
    bit ok;
    logic [255:0] got, exp_v;
    clear_q();
    exp_q.push_back(PT_A);
    send_block(encrypt(PT_A), acc, ok);
    tvalid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_accept: tready never rose (expected 1)", name);
    end
    wait_results(1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: no valid pulse seen, expected 1", name);
    end else begin
      got = pt_q.pop_front();
      exp_v = exp_q.pop_front();
      lat = vcyc_q.pop_front() - acc;
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL %s_data: got %h expected %h", name, got, exp_v);
      end
      total++;
      if (lat != 31) begin
        bad++;
        $display("FAIL %s_latency: got %0d expected 31", name, lat);
      end
    end
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
    total++;
    if (plaintext !== '0) begin bad++; $display("FAIL reset_pt: got %h expected 0", plaintext); end
    total++;
    if (tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b expected 0", tready); end
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_not_ready();
    int err;
    clear_q();
    tvalid = 1'b1;
    ciphertext = encrypt(PT_A);
    err = 0;
    for (int i = 0; i < 10; i++) begin
      if (tready !== 1'b0) err++;
      tick();
    end
    total++;
    if (err != 0) begin bad++; $display("FAIL nr_empty_tready: high %0d cycles expected 0", err); end
    // S-box full, keys not yet loaded
    tvalid = 1'b0;
    load_sbox();
    tvalid = 1'b1;
    err = 0;
    for (int i = 0; i < 10; i++) begin
      if (tready !== 1'b0) err++;
      tick();
    end
    total++;
    if (err != 0) begin bad++; $display("FAIL nr_nokey_tready: high %0d cycles expected 0", err); end
    // keys first, then S-box with tvalid held through the final write
    tvalid = 1'b0;
    do_reset();
    load_std_keys();
    tvalid = 1'b1;
    err = 0;
    for (int i = 0; i < 256; i++) begin
      sbox_valid = 1'b1;
      sbox_out = 8'(255 - i);
      if (tready !== 1'b0) err++;
      tick();
    end
    sbox_valid = 1'b0;
    tvalid = 1'b0;
    total++;
    if (err != 0) begin bad++; $display("FAIL nr_load_tready: high %0d cycles expected 0", err); end
    total++;
    if (tready !== 1'b1) begin bad++; $display("FAIL nr_ready_after: got %b expected 1", tready); end
    repeat (40) tick();
    total++;
    if (pt_q.size() != 0) begin bad++; $display("FAIL nr_no_valid: got %0d pulses expected 0", pt_q.size()); end
  endtask

  task automatic test_round_trip();
    round_trip("rt");
  endtask

  task automatic test_zero_keys();
    int acc;
    bit ok;
    logic [255:0] got, exp_v;
    clear_q();
    load_keys('0, '0, '0, '0, '0);
    exp_q.push_back({128'h0, {128{1'b1}}});
    send_block('0, acc, ok);
    tvalid = 1'b0;
    wait_results(1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL zk_timeout: no valid pulse seen, expected 1");
    end else begin
      got = pt_q.pop_front();
      exp_v = exp_q.pop_front();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL zk_data: got %h expected %h", got, exp_v); end
    end
    load_std_keys();
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    clear_q();
    send_block(encrypt(PT_A), acc, ok);
    tvalid = 1'b0;
    repeat (14) tick();
    do_reset();
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL rm_state: got %0d expected 0", dbg_state); end
    total++;
    if (tready !== 1'b0) begin bad++; $display("FAIL rm_tready: got %b expected 0", tready); end
    total++;
    if (plaintext !== '0) begin bad++; $display("FAIL rm_pt: got %h expected 0", plaintext); end
    repeat (40) tick();
    total++;
    if (pt_q.size() != 0) begin bad++; $display("FAIL rm_stray: got %0d pulses expected 0", pt_q.size()); end
    load_sbox();
    load_std_keys();
    round_trip("rm");
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, v0, v1;
    bit ok0, ok1, ok;
    logic [255:0] got, exp_v;
    clear_q();
    exp_q.push_back(PT_A);
    exp_q.push_back(PT_B);
    send_block(encrypt(PT_A), acc0, ok0);
    send_block(encrypt(PT_B), acc1, ok1);
    tvalid = 1'b0;
    total++;
    if (!(ok0 && ok1)) begin bad++; $display("FAIL b2b_accept: accepted %0d of 2 expected 2", ok0 + ok1); end
    wait_results(2, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_timeout: got %0d pulses expected 2", pt_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        got = pt_q.pop_front();
        exp_v = exp_q.pop_front();
        total++;
        if (got !== exp_v) begin bad++; $display("FAIL b2b_data%0d: got %h expected %h", i, got, exp_v); end
      end
      v0 = vcyc_q.pop_front();
      v1 = vcyc_q.pop_front();
      total++;
      if (v1 - v0 != 32) begin bad++; $display("FAIL b2b_spacing: got %0d expected 32", v1 - v0); end
      total++;
      if (acc1 - acc0 != 32) begin bad++; $display("FAIL b2b_accept_gap: got %0d expected 32", acc1 - acc0); end
      total++;
      if (v0 - acc0 != 31) begin bad++; $display("FAIL b2b_latency: got %0d expected 31", v0 - acc0); end
    end
  endtask

  task automatic test_ignored();
    int acc;
    bit ok;
    logic [255:0] got;
    clear_q();
    for (int i = 0; i < 5; i++) begin
      sbox_valid = 1'b1;
      sbox_out = 8'h5a;
      tick();
    end
    sbox_valid = 1'b0;
    send_block(encrypt(PT_A), acc, ok);
    tvalid = 1'b0;
    repeat (8) tick();
    load_keys('0, '0, '0, '0, '0);
    wait_results(1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ign_timeout: no valid pulse seen, expected 1");
    end else begin
      got = pt_q.pop_front();
      total++;
      if (got !== PT_A) begin bad++; $display("FAIL ign_data: got %h expected %h", got, PT_A); end
    end
    repeat (3) tick();
    round_trip("ign_keep");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_sbox[i] = 8'(255 - i);
    m_keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
    m_keys[1] = 128'h101112131415161718191a1b1c1d1e1f;
    m_keys[2] = 128'h202122232425262728292a2b2c2d2e2f;
    m_keys[3] = 128'h303132333435363738393a3b3c3d3e3f;
    m_keys[4] = 128'h404142434445464748494a4b4c4d4e4f;
    test_reset();
    test_not_ready();
    test_round_trip();
    test_zero_keys();
    test_reset_mid();
    test_back_to_back();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
